// File: rtl/intra_blk_seq_pkg.sv
// Shared types and constants for the intra 4x4 block sequencer.
// Holds MB coordinate widths, block-count limits, watchdog width and the
// sequencer state encoding (intra_seq_*_s).
package intra_blk_seq_pkg;

  localparam int unsigned MB_X_BITS = 8;
  localparam int unsigned MB_Y_BITS = 8;
  localparam int unsigned BLK_BITS  = 5;
  localparam int unsigned WD_BITS   = 8;

  // Block 23 is the last Cr 4x4 block of a macroblock
  localparam logic [BLK_BITS-1:0] LAST_BLK = BLK_BITS'(23);
  localparam logic [WD_BITS-1:0]  WD_MAX   = WD_BITS'(255);

  typedef enum logic [2:0] {
    intra_seq_idle_s      = 3'd0,
    intra_seq_issue_s     = 3'd1,
    intra_seq_wait_pred_s = 3'd2,
    intra_seq_wait_res_s  = 3'd3,
    intra_seq_sum_s       = 3'd4,
    intra_seq_gap_s       = 3'd5
  } intra_seq_state_e;

  // True for the two states that wait on the predictor or residual path
  function automatic logic is_wait_state(input intra_seq_state_e s);
    return (s == intra_seq_wait_pred_s) || (s == intra_seq_wait_res_s);
  endfunction

endpackage

// File: rtl/intra_mb_pos_cnt.sv
// Macroblock position counter: raster-scan mb_x/mb_y with picture wrap.
// Ports: clk, rst_n, ena (stall), advance (one MB finished),
//        pic_width_in_mbs_minus1 / pic_height_in_mbs_minus1 (picture size),
//        mb_x / mb_y (current MB), pic_done (pulse when the last MB wraps).
module intra_mb_pos_cnt
  import intra_blk_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 advance,
  input  logic [MB_X_BITS-1:0] pic_width_in_mbs_minus1,
  input  logic [MB_Y_BITS-1:0] pic_height_in_mbs_minus1,
  output logic [MB_X_BITS-1:0] mb_x,
  output logic [MB_Y_BITS-1:0] mb_y,
  output logic                 pic_done
);

  // Raster advance; pic_done is a single enabled-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_x     <= '0;
      mb_y     <= '0;
      pic_done <= 1'b0;
    end else if (ena) begin
      pic_done <= 1'b0;
      if (advance) begin
        if (mb_x == pic_width_in_mbs_minus1) begin
          mb_x <= '0;
          if (mb_y == pic_height_in_mbs_minus1) begin
            mb_y     <= '0;
            pic_done <= 1'b1;
          end else begin
            mb_y <= mb_y + MB_Y_BITS'(1);
          end
        end else begin
          mb_x <= mb_x + MB_X_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/intra_blk_seq.sv
// Intra macroblock sequencer: walks 24 4x4 blocks (16 luma, 4 Cb, 4 Cr),
// handshaking each with the intra predictor (start/valid) and the residual
// path (residual_valid), then strobes sum_valid for reconstruction.
// Ports: clk, rst_n, ena (global stall), mb_start, picture size in MBs,
//        valid, residual_valid -> start, blk4x4_counter, sum_valid,
//        mb_x, mb_y, mb_done, pic_done, timeout (watchdog build only).
// Build option: INTRA_SEQ_WATCHDOG_EN adds a 255-cycle wait watchdog that
// sets a sticky timeout and returns the FSM to idle.
module intra_blk_seq
  import intra_blk_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 mb_start,
  input  logic [MB_X_BITS-1:0] pic_width_in_mbs_minus1,
  input  logic [MB_Y_BITS-1:0] pic_height_in_mbs_minus1,
  input  logic                 valid,
  input  logic                 residual_valid,
  output logic                 start,
  output logic [BLK_BITS-1:0]  blk4x4_counter,
  output logic                 sum_valid,
  output logic [MB_X_BITS-1:0] mb_x,
  output logic [MB_Y_BITS-1:0] mb_y,
  output logic                 mb_done,
`ifdef INTRA_SEQ_WATCHDOG_EN
  output logic                 timeout,
`endif
  output logic                 pic_done
);

  intra_seq_state_e      state, state_nxt;
  logic [BLK_BITS-1:0]   blk_nxt;
  logic                  start_nxt, sum_valid_nxt, mb_done_nxt;
  logic                  advance;
`ifdef INTRA_SEQ_WATCHDOG_EN
  logic [WD_BITS-1:0]    wd_cnt, wd_nxt;
  logic                  timeout_nxt;
`endif

  // State and registered outputs; everything holds while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= intra_seq_idle_s;
      blk4x4_counter <= '0;
      start          <= 1'b0;
      sum_valid      <= 1'b0;
      mb_done        <= 1'b0;
`ifdef INTRA_SEQ_WATCHDOG_EN
      wd_cnt         <= '0;
      timeout        <= 1'b0;
`endif
    end else if (ena) begin
      state          <= state_nxt;
      blk4x4_counter <= blk_nxt;
      start          <= start_nxt;
      sum_valid      <= sum_valid_nxt;
      mb_done        <= mb_done_nxt;
`ifdef INTRA_SEQ_WATCHDOG_EN
      wd_cnt         <= wd_nxt;
      timeout        <= timeout_nxt;
`endif
    end
  end

  // Next state; start/sum_valid are registered images of the next state
  always_comb begin
    state_nxt   = state;
    blk_nxt     = blk4x4_counter;
    mb_done_nxt = 1'b0;
    advance     = 1'b0;
`ifdef INTRA_SEQ_WATCHDOG_EN
    wd_nxt      = wd_cnt;
    timeout_nxt = timeout;
`endif

    case (state)
      intra_seq_idle_s: begin
        if (mb_start) begin
          blk_nxt   = '0;
          state_nxt = intra_seq_issue_s;
        end
      end
      intra_seq_issue_s:     state_nxt = intra_seq_wait_pred_s;
      intra_seq_wait_pred_s: if (valid) state_nxt = intra_seq_wait_res_s;
      intra_seq_wait_res_s:  if (residual_valid) state_nxt = intra_seq_sum_s;
      intra_seq_sum_s:       state_nxt = intra_seq_gap_s;
      intra_seq_gap_s: begin
        if (blk4x4_counter == LAST_BLK) begin
          mb_done_nxt = 1'b1;
          advance     = 1'b1;
          state_nxt   = intra_seq_idle_s;
        end else begin
          blk_nxt   = blk4x4_counter + BLK_BITS'(1);
          state_nxt = intra_seq_issue_s;
        end
      end
      default: state_nxt = intra_seq_idle_s;
    endcase

`ifdef INTRA_SEQ_WATCHDOG_EN
    // Restart the count on entry to a wait state, count while staying
    if (is_wait_state(state_nxt) && (state_nxt != state)) begin
      wd_nxt = '0;
    end else if (is_wait_state(state)) begin
      wd_nxt = wd_cnt + WD_BITS'(1);
    end
    // A handshake arriving on the limit cycle still wins over the timeout
    if (is_wait_state(state) && (state_nxt == state) && (wd_cnt == WD_MAX)) begin
      timeout_nxt = 1'b1;
      state_nxt   = intra_seq_idle_s;
    end
`endif

    start_nxt     = (state_nxt == intra_seq_issue_s);
    sum_valid_nxt = (state_nxt == intra_seq_sum_s);
  end

  intra_mb_pos_cnt u_mb_pos_cnt (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ena                      (ena),
    .advance                  (advance),
    .pic_width_in_mbs_minus1  (pic_width_in_mbs_minus1),
    .pic_height_in_mbs_minus1 (pic_height_in_mbs_minus1),
    .mb_x                     (mb_x),
    .mb_y                     (mb_y),
    .pic_done                 (pic_done)
  );

endmodule

// File: doc/intra_blk_seq.md
INTRA_BLK_SEQ -- requirements
Module: intra_blk_seq

Interface
REQ-001 Port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 Port ena, input, 1 bit: global stall; no state, counter or output register updates while low.
REQ-004 Port mb_start, input, 1 bit: request to decode one macroblock, sampled only in IDLE.
REQ-005 Port pic_width_in_mbs_minus1, input, `mb_x_bits: picture width in MBs minus 1.
REQ-006 Port pic_height_in_mbs_minus1, input, `mb_y_bits: picture height in MBs minus 1.
REQ-007 Port valid, input, 1 bit: prediction-done level from the intra predictor FSM.
REQ-008 Port residual_valid, input, 1 bit: residual for the current 4x4 block is ready.
REQ-009 Port start, output, 1 bit: one-cycle prediction request to the intra predictor FSM.
REQ-010 Port blk4x4_counter, output, 5 bits: current block; 0-15 luma, 16-19 Cb, 20-23 Cr.
REQ-011 Port sum_valid, output, 1 bit: reconstruction-written strobe; the predictor acts on its rising edge.
REQ-012 Port mb_x, output, `mb_x_bits: current MB column.
REQ-013 Port mb_y, output, `mb_y_bits: current MB row.
REQ-014 Port mb_done, output, 1 bit: one-cycle pulse after block 23 completes.
REQ-015 Port pic_done, output, 1 bit: one-cycle pulse coincident with mb_done of the last MB in the picture.
REQ-016 Port timeout, output, 1 bit: sticky watchdog error; present only under INTRA_SEQ_WATCHDOG_EN.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_PRED, WAIT_RES, SUM, GAP; all outputs are registered.
REQ-018 In IDLE with mb_start=1, the FSM SHALL clear blk4x4_counter to 0 and go to ISSUE.
REQ-019 In ISSUE, start=1 for exactly one enabled cycle, then the FSM goes to WAIT_PRED.
REQ-020 In WAIT_PRED, the FSM goes to WAIT_RES on the first cycle valid=1; valid is not sampled in the ISSUE cycle.
REQ-021 In WAIT_RES, the FSM goes to SUM on residual_valid=1.
REQ-022 In SUM, sum_valid=1 for exactly one cycle, then the FSM goes to GAP.
REQ-023 In GAP, sum_valid=0, which guarantees a low cycle between successive sum_valid pulses.
REQ-024 In GAP with blk4x4_counter<23, the FSM increments blk4x4_counter and goes to ISSUE.
REQ-025 In GAP with blk4x4_counter=23, the FSM pulses mb_done, advances the MB position and returns to IDLE.
REQ-026 MB advance: mb_x+1; if mb_x=pic_width_in_mbs_minus1, then mb_x=0 and mb_y+1.
REQ-027 At the last MB (both at max), mb_x and mb_y SHALL wrap to 0 and pic_done SHALL pulse.
REQ-028 mb_start outside IDLE SHALL be ignored; it is not queued.
REQ-029 valid and residual_valid high together in WAIT_PRED SHALL still take two cycles: WAIT_PRED then WAIT_RES.
REQ-030 Minimum per-block cycle count is 5 (ISSUE, WAIT_PRED, WAIT_RES, SUM, GAP); mb_x and mb_y are stable during the whole MB.

Reset
REQ-031 On rst_n low, state=IDLE and start, sum_valid, mb_done, pic_done, timeout, blk4x4_counter, mb_x, mb_y are all 0, regardless of ena.
REQ-032 Reset mid-MB SHALL abandon the MB; the next mb_start begins at block 0 of MB (0,0).

Configuration
REQ-033 With INTRA_SEQ_WATCHDOG_EN defined, an 8-bit counter clears on entering WAIT_PRED or WAIT_RES and increments each enabled cycle there.
REQ-034 Under INTRA_SEQ_WATCHDOG_EN, when the counter reaches 255, timeout is set (sticky until reset) and the FSM forces IDLE.
REQ-035 Without INTRA_SEQ_WATCHDOG_EN, the counter and the timeout port are absent and waits are unbounded.

Structure
REQ-036 State encodings (intra_seq_*_s) and the constant 23 (last block) SHALL live in the shared defines.v, alongside `mb_x_bits and `mb_y_bits.
REQ-037 MB position counting SHALL be a sub-module intra_mb_pos_cnt (inputs: advance, widths; outputs: mb_x, mb_y, pic_done).

Verification
REQ-038 Scenario: mb_start at cycle 0, then valid and residual_valid each 1 cycle after request -> 24 start pulses, blk 0..23, mb_done once, mb_x 0->1.
REQ-039 Scenario: width-1=1, height-1=0, two MBs -> after the second mb_done: mb_x=0, mb_y=0, pic_done=1 for one cycle.
REQ-040 Scenario: residual_valid held high constantly -> sum_valid pulses separated by at least 4 low cycles; never two consecutive highs.
REQ-041 Scenario: ena low 10 cycles during WAIT_RES at blk 7 -> blk4x4_counter, state and outputs frozen; resumes at blk 7.
REQ-042 Scenario: rst_n low during blk 12 -> all outputs 0 asynchronously; next mb_start yields start with blk 0.
REQ-043 Scenario (INTRA_SEQ_WATCHDOG_EN): valid never asserted -> timeout=1 exactly 256 enabled cycles after entering WAIT_PRED; state IDLE.
